lif_tdm_scheduler: RTL

//   Time-division-multiplexed controller that sweeps one shared weighted-LIF update datapath over NUM_NEURONS virtual neurons.

---
 rtl/lif_tdm_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed weighted-LIF controller: one shared update datapath sweeps a
// feed-forward chain of NUM_NEURONS virtual neurons, one neuron per cycle per tick.
module lif_tdm_scheduler #(
  parameter int         NUM_NEURONS    = 4,
  parameter int         IDX_W          = 4,
  parameter logic [7:0] THRESHOLD      = 8'd200,
  parameter logic [7:0] INIT_WEIGHT    = 8'd255,
  parameter bit         RESET_ON_SPIKE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   tick_i,
  input  logic [7:0]             cur_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tick_drop_o,
  output logic [NUM_NEURONS-1:0] spike_o,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [7:0]             cfg_wdata,
  output logic                   cfg_err_o,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [7:0]             rd_data
);

  localparam int               PW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                 st_q, st_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             cur_q, cur_d;
  logic [7:0]             prev_q, prev_d;
  logic [NUM_NEURONS-1:0] acc_q, acc_d;
  logic [NUM_NEURONS-1:0] spike_q, spike_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;
  logic                   cerr_q, cerr_d;
  logic                   mem_we, wgt_we;

  logic [7:0] mem_q [NUM_NEURONS];
  logic [7:0] wgt_q [NUM_NEURONS];

  logic [PW-1:0] cur_idx;
  logic [7:0]    in_val, wtd, nxt, wb_val;
  logic [15:0]   prod;
  logic [8:0]    sum;
  logic          spk;

  always_comb begin
    cur_idx = idx_q[PW-1:0];
    if (idx_q == {IDX_W{1'b0}}) begin
      in_val = cur_q;
    end else begin
      in_val = prev_q;
    end
    prod = {8'd0, in_val} * {8'd0, wgt_q[cur_idx]};
    wtd  = 8'(prod >> 8);
    sum  = {1'b0, wtd} + {2'b00, mem_q[cur_idx][7:1]};
    if (sum[8]) begin
      nxt = 8'hFF;
    end else begin
      nxt = sum[7:0];
    end
    spk = (nxt >= THRESHOLD);
    if (spk && RESET_ON_SPIKE) begin
      wb_val = 8'd0;
    end else begin
      wb_val = nxt;
    end
  end

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    spike_d = spike_q;
    drop_d  = 1'b0;
    cerr_d  = 1'b0;
    mem_we  = 1'b0;
    wgt_we  = 1'b0;
    if (ena) begin
      case (st_q)
        S_IDLE: begin
          if (tick_i) begin
            st_d   = S_SWEEP;
            cur_d  = cur_i;
            idx_d  = {IDX_W{1'b0}};
            acc_d  = {NUM_NEURONS{1'b0}};
            prev_d = mem_q[0];
          end else begin
            st_d = S_IDLE;
          end
        end
        S_SWEEP: begin
          mem_we         = 1'b1;
          acc_d[cur_idx] = spk;
          // Old state of this neuron feeds the next one before it is overwritten.
          prev_d         = mem_q[cur_idx];
          drop_d         = tick_i;
          if (idx_q == LAST_IDX) begin
            st_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          spike_d = acc_q;
          drop_d  = tick_i;
          st_d    = S_IDLE;
        end
        default: begin
          st_d = S_IDLE;
        end
      endcase
      if (cfg_we) begin
        if ((st_q == S_IDLE) && ({1'b0, cfg_addr} < N_EXT)) begin
          wgt_we = 1'b1;
        end else begin
          cerr_d = 1'b1;
        end
      end else begin
        cerr_d = 1'b0;
      end
    end else begin
      st_d = st_q;
    end
    busy_d = (st_d != S_IDLE);
    done_d = (st_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      cur_q   <= 8'd0;
      prev_q  <= 8'd0;
      acc_q   <= {NUM_NEURONS{1'b0}};
      spike_q <= {NUM_NEURONS{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      cerr_q  <= cerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (mem_we) begin
      mem_q[cur_idx] <= wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        wgt_q[i] <= INIT_WEIGHT;
      end
    end else if (wgt_we) begin
      wgt_q[cfg_addr[PW-1:0]] <= cfg_wdata;
    end
  end

  always_comb begin
    if ({1'b0, rd_addr} < N_EXT) begin
      rd_data = mem_q[rd_addr[PW-1:0]];
    end else begin
      rd_data = 8'd0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tick_drop_o = drop_q;
  assign spike_o     = spike_q;
  assign cfg_err_o   = cerr_q;

endmodule
